glitch_wb_master: RTL and testbench

Wishbone initiator that drives the 8-bit glitch peripheral register map from the responder side's opposite end. It accepts 32-bit glitch entries over a valid/ready port. For each entry it polls the peripheral's FIFO-full flag, then writes the entry as four byte writes to the queue registers, with the byte-3 write committing the entry. It also services on-demand status snapshots (ready, FIFO empty). It sits between the host command decoder and the glitch peripheral's Wishbone slave port, in the `clk_i` domain.

---
 rtl/glitch_wb_master_pkg.sv | 50 +++++
 rtl/glitch_wb_access.sv | 57 +++++
 rtl/glitch_wb_master.sv | 149 ++++++++++++++
 tb/tb_glitch_wb_master.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_wb_master_pkg.sv
// Shared types, glitch peripheral register addresses and the per-state access lookup
// used by the glitch Wishbone initiator.
package glitch_wb_master_pkg;

  localparam int unsigned ADR_W = 4;
  localparam int unsigned DAT_W = 8;

  localparam logic [ADR_W-1:0] GLITCH_STATUS     = 4'h0;
  localparam logic [ADR_W-1:0] GLITCH_QUEUE_0    = 4'h1;
  localparam logic [ADR_W-1:0] GLITCH_QUEUE_1    = 4'h2;
  localparam logic [ADR_W-1:0] GLITCH_QUEUE_2    = 4'h3;
  localparam logic [ADR_W-1:0] GLITCH_QUEUE_3    = 4'h4;
  localparam logic [ADR_W-1:0] GLITCH_FIFO_EMPTY = 4'h5;
  localparam logic [ADR_W-1:0] GLITCH_FIFO_FULL  = 4'h6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_STS_RD,
    ST_EMPTY_RD,
    ST_FULL_RD,
    ST_BACKOFF,
    ST_WR0,
    ST_WR1,
    ST_WR2,
    ST_WR3
  } state_e;

  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } acc_req_t;

  // Bus access issued on behalf of a given sequencer state.
  function automatic acc_req_t access_for(input state_e st, input logic [31:0] entry);
    acc_req_t r;
    r = '{we: 1'b0, adr: GLITCH_STATUS, dat: '0};
    case (st)
      ST_EMPTY_RD: r.adr = GLITCH_FIFO_EMPTY;
      ST_FULL_RD:  r.adr = GLITCH_FIFO_FULL;
      ST_WR0:      r = '{we: 1'b1, adr: GLITCH_QUEUE_0, dat: entry[7:0]};
      ST_WR1:      r = '{we: 1'b1, adr: GLITCH_QUEUE_1, dat: entry[15:8]};
      ST_WR2:      r = '{we: 1'b1, adr: GLITCH_QUEUE_2, dat: entry[23:16]};
      ST_WR3:      r = '{we: 1'b1, adr: GLITCH_QUEUE_3, dat: entry[31:24]};
      default:     ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/glitch_wb_access.sv
// Single-beat Wishbone master: registered strobe, qualified ack, mandatory gap cycle
// and per-access timeout.
module glitch_wb_access
  import glitch_wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  acc_req_t         req_i,
  output logic             ack_o,
  output logic             timeout_o,
  output logic [DAT_W-1:0] rdata_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] dat_o,
  input  logic [DAT_W-1:0] dat_i,
  input  logic             ack_i
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic       stb_q;
  logic [7:0] cnt_q;

  // An ack only counts once the responder has seen the strobe for a full cycle;
  // this also rejects the stale ack it emits during the gap.
  assign ack_o     = stb_o & stb_q & ack_i;
  assign timeout_o = stb_o & ~ack_o & (cnt_q == TO_LAST);
  assign rdata_o   = dat_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stb_o <= 1'b0;
      stb_q <= 1'b0;
      we_o  <= 1'b0;
      adr_o <= '0;
      dat_o <= '0;
      cnt_q <= '0;
    end else begin
      stb_q <= stb_o;
      if (stb_o) begin
        if (ack_o || timeout_o) stb_o <= 1'b0;
        else                    cnt_q <= cnt_q + 8'd1;
      end else if (start_i) begin
        stb_o <= 1'b1;
        we_o  <= req_i.we;
        adr_o <= req_i.adr;
        dat_o <= req_i.dat;
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/glitch_wb_master.sv
// Wishbone initiator feeding 32-bit glitch entries into the glitch peripheral queue
// and servicing on-demand status snapshots.
//
// state    | meaning
// IDLE     | waiting; pending status request wins over a new entry
// STS_RD   | reading STATUS
// EMPTY_RD | reading FIFO_EMPTY, then publishing the snapshot
// FULL_RD  | polling FIFO_FULL before writing an entry
// BACKOFF  | waiting POLL_GAP cycles before the next FIFO_FULL poll
// WR0..WR3 | writing QUEUE_0..QUEUE_3; the QUEUE_3 write commits the entry
module glitch_wb_master
  import glitch_wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned POLL_GAP = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  input  logic [31:0]      req_data_i,
  output logic             req_ready_o,
  output logic             done_o,
  output logic             err_o,
  input  logic             sts_req_i,
  output logic             sts_valid_o,
  output logic             sts_ready_o,
  output logic             sts_empty_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] dat_o,
  input  logic [DAT_W-1:0] dat_i,
  input  logic             ack_i
);

  state_e           state_q, state_d;
  logic [31:0]      entry_q;
  logic             sts_pend_q;
  logic             sts_rdy_cap_q;
  logic [7:0]       bo_cnt_q;

  logic             acc_start;
  acc_req_t         acc_req;
  logic             acc_ack;
  logic             acc_to;
  logic [DAT_W-1:0] acc_rdata;
  logic             rd_bit;
  logic             rdata_unused;

  assign rd_bit       = acc_rdata[0];
  assign rdata_unused = ^acc_rdata[DAT_W-1:1];
  assign req_ready_o  = (state_q == ST_IDLE) & ~sts_pend_q;

  glitch_wb_access #(
    .TIMEOUT (TIMEOUT)
  ) u_access (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (acc_start),
    .req_i     (acc_req),
    .ack_o     (acc_ack),
    .timeout_o (acc_to),
    .rdata_o   (acc_rdata),
    .stb_o     (stb_o),
    .we_o      (we_o),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .dat_i     (dat_i),
    .ack_i     (ack_i)
  );

  always_comb begin
    state_d   = state_q;
    acc_start = 1'b0;
    acc_req   = access_for(state_q, entry_q);
    unique case (state_q)
      ST_IDLE: begin
        if (sts_pend_q) begin
          acc_start = 1'b1;
          acc_req   = access_for(ST_STS_RD, entry_q);
          state_d   = ST_STS_RD;
        end else if (req_valid_i) begin
          acc_start = 1'b1;
          acc_req   = access_for(ST_FULL_RD, entry_q);
          state_d   = ST_FULL_RD;
        end
      end
      ST_BACKOFF: begin
        if (bo_cnt_q == 8'd0) begin
          acc_start = 1'b1;
          acc_req   = access_for(ST_FULL_RD, entry_q);
          state_d   = ST_FULL_RD;
        end
      end
      ST_STS_RD, ST_EMPTY_RD, ST_FULL_RD, ST_WR0, ST_WR1, ST_WR2, ST_WR3: begin
        // The strobe is low here only in the gap after the previous access.
        acc_start = ~stb_o;
        if (acc_to) begin
          state_d = ST_IDLE;
        end else if (acc_ack) begin
          case (state_q)
            ST_STS_RD:  state_d = ST_EMPTY_RD;
            ST_FULL_RD: state_d = rd_bit ? ST_BACKOFF : ST_WR0;
            ST_WR0:     state_d = ST_WR1;
            ST_WR1:     state_d = ST_WR2;
            ST_WR2:     state_d = ST_WR3;
            default:    state_d = ST_IDLE;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      entry_q       <= '0;
      sts_pend_q    <= 1'b0;
      sts_rdy_cap_q <= 1'b0;
      bo_cnt_q      <= '0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      sts_valid_o   <= 1'b0;
      sts_ready_o   <= 1'b0;
      sts_empty_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_o      <= acc_ack & (state_q == ST_WR3);
      err_o       <= acc_to;
      sts_valid_o <= acc_ack & (state_q == ST_EMPTY_RD);

      if (req_ready_o && req_valid_i) entry_q <= req_data_i;

      if (sts_req_i)                               sts_pend_q <= 1'b1;
      else if (acc_ack && state_q == ST_EMPTY_RD)  sts_pend_q <= 1'b0;

      if (acc_ack && state_q == ST_STS_RD) sts_rdy_cap_q <= rd_bit;
      if (acc_ack && state_q == ST_EMPTY_RD) begin
        sts_ready_o <= sts_rdy_cap_q;
        sts_empty_o <= rd_bit;
      end

      if (acc_ack && state_q == ST_FULL_RD)          bo_cnt_q <= 8'(POLL_GAP - 1);
      else if (state_q == ST_BACKOFF && bo_cnt_q != 8'd0) bo_cnt_q <= bo_cnt_q - 8'd1;
    end
  end

endmodule

// File: tb/tb_glitch_wb_master.sv
// Directed bench for glitch_wb_master with a responder that always emits a stale
// ack in the gap cycle.
module tb_glitch_wb_master;
  import glitch_wb_master_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        req_valid_i = 1'b0;
  logic [31:0] req_data_i = '0;
  logic        req_ready_o, done_o, err_o;
  logic        sts_req_i = 1'b0;
  logic        sts_valid_o, sts_ready_o, sts_empty_o;
  logic        stb_o, we_o;
  logic [3:0]  adr_o;
  logic [7:0]  dat_o;
  logic [7:0]  dat_i;
  logic        ack_i;

  always #5 clk_i = ~clk_i;

  glitch_wb_master #(.TIMEOUT(16), .POLL_GAP(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .sts_req_i   (sts_req_i),
    .sts_valid_o (sts_valid_o),
    .sts_ready_o (sts_ready_o),
    .sts_empty_o (sts_empty_o),
    .stb_o       (stb_o),
    .we_o        (we_o),
    .adr_o       (adr_o),
    .dat_o       (dat_o),
    .dat_i       (dat_i),
    .ack_i       (ack_i)
  );

  int n_chk = 0;
  int n_fail = 0;

  // responder state
  int         full_left = 0;
  logic       sts_val = 1'b0;
  logic       empty_val = 1'b0;
  logic       hold_en = 1'b0;
  logic [3:0] hold_adr = '0;
  int         n_stb = 0;
  logic       stb_prev = 1'b0;
  logic       rd_bit;
  logic [12:0] log_q[$];

  // Acks one cycle after seeing the strobe; the registered ack naturally lands
  // as a stale ack in the gap cycle too.
  initial begin : responder
    ack_i = 1'b0;
    dat_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        ack_i = 1'b0;
        dat_i = '0;
        stb_prev = 1'b0;
      end else begin
        ack_i = stb_prev && !(hold_en && adr_o == hold_adr);
        if (stb_o && !stb_prev) n_stb++;
        dat_i = 8'h00;
        if (stb_o && stb_prev && ack_i) begin
          if (!we_o) begin
            if (adr_o == GLITCH_FIFO_FULL)    rd_bit = (full_left > 0);
            else if (adr_o == GLITCH_STATUS)  rd_bit = sts_val;
            else                              rd_bit = empty_val;
            dat_i = {7'h7F, rd_bit};
            if (adr_o == GLITCH_FIFO_FULL && full_left > 0) full_left--;
            log_q.push_back({1'b0, adr_o, dat_i});
          end else begin
            log_q.push_back({1'b1, adr_o, dat_o});
          end
        end
        stb_prev = stb_o;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " stb_o"}, int'(stb_o), 0);
    chk({tag, " we_o"}, int'(we_o), 0);
    chk({tag, " adr_o"}, int'(adr_o), 0);
    chk({tag, " dat_o"}, int'(dat_o), 0);
    chk({tag, " done_o"}, int'(done_o), 0);
    chk({tag, " err_o"}, int'(err_o), 0);
    chk({tag, " sts_valid_o"}, int'(sts_valid_o), 0);
    chk({tag, " sts_ready_o"}, int'(sts_ready_o), 0);
    chk({tag, " sts_empty_o"}, int'(sts_empty_o), 0);
    chk({tag, " req_ready_o"}, int'(req_ready_o), 1);
  endtask

  // observation results, cycle 0 = first cycle after acceptance edge
  int   first_done, last_done, cnt_done;
  int   first_err, cnt_err;
  int   first_sv, cnt_sv;
  int   cnt_both;
  logic stb_hist[256];
  logic rdy_hist[256];

  task automatic watch(input int ncyc, input int drop_at, input int sts_at);
    first_done = -1; last_done = -1; cnt_done = 0;
    first_err = -1; cnt_err = 0;
    first_sv = -1; cnt_sv = 0;
    cnt_both = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c < 256) begin
        stb_hist[c] = stb_o;
        rdy_hist[c] = req_ready_o;
      end
      if (done_o) begin
        if (first_done < 0) first_done = c;
        last_done = c;
        cnt_done++;
      end
      if (err_o) begin
        if (first_err < 0) first_err = c;
        cnt_err++;
      end
      if (sts_valid_o) begin
        if (first_sv < 0) first_sv = c;
        cnt_sv++;
      end
      if (done_o && err_o) cnt_both++;
      if (c == drop_at) req_valid_i = 1'b0;
      sts_req_i = (c == sts_at);
      @(negedge clk_i);
    end
    sts_req_i = 1'b0;
  endtask

  task automatic send_entry(input logic [31:0] d);
    req_valid_i = 1'b1;
    req_data_i  = d;
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  typedef struct {
    logic [31:0] data;
    int          full_polls;
    logic [7:0]  b0, b1, b2, b3;
    int          exp_done;
    int          exp_stb;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    logic [12:0] e;
    logic [3:0]  qa[4];
    logic [7:0]  qb[4];
    qa[0] = GLITCH_QUEUE_0; qa[1] = GLITCH_QUEUE_1; qa[2] = GLITCH_QUEUE_2; qa[3] = GLITCH_QUEUE_3;
    qb[0] = v.b0; qb[1] = v.b1; qb[2] = v.b2; qb[3] = v.b3;
    log_q.delete();
    n_stb = 0;
    full_left = v.full_polls;
    send_entry(v.data);
    watch(v.exp_done + 4, -1, -1);
    chk("done_cycle", first_done, v.exp_done);
    chk("done_count", cnt_done, 1);
    chk("err_count", cnt_err, 0);
    chk("ready_at_done", int'(rdy_hist[v.exp_done]), 1);
    chk("strobes", n_stb, v.exp_stb);
    chk("access_count", log_q.size(), v.full_polls + 5);
    for (int k = 0; k < v.full_polls + 5; k++) begin
      if (k <= v.full_polls) e = {1'b0, GLITCH_FIFO_FULL, 7'h7F, (k < v.full_polls)};
      else                   e = {1'b1, qa[k - v.full_polls - 1], qb[k - v.full_polls - 1]};
      if (k < log_q.size()) chk("access", int'(log_q[k]), int'(e));
    end
  endtask

  initial begin
    vecs[0] = '{32'hA1B2C3D4, 0, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 14, 5};
    vecs[1] = '{32'h5A5A0FF0, 2, 8'hF0, 8'h0F, 8'h5A, 8'h5A, 26, 7};
    vecs[2] = '{32'h00000000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 14, 5};
    vecs[3] = '{32'hFFFFFFFF, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 20, 6};
    vecs[4] = '{32'h12345678, 0, 8'h78, 8'h56, 8'h34, 8'h12, 14, 5};

    #2 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    chk_reset_outputs("reset");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      repeat (3) @(negedge clk_i);
    end

    // back-to-back entries, stale ack in every gap
    log_q.delete();
    n_stb = 0;
    full_left = 0;
    req_valid_i = 1'b1;
    req_data_i = 32'h11223344;
    @(negedge clk_i);
    req_data_i = 32'hCAFEBEEF;
    watch(34, 15, -1);
    chk("b2b first_done", first_done, 14);
    chk("b2b ready_at_14", int'(rdy_hist[14]), 1);
    chk("b2b stb_at_15", int'(stb_hist[15]), 1);
    chk("b2b last_done", last_done, 29);
    chk("b2b done_count", cnt_done, 2);
    chk("b2b strobes", n_stb, 10);
    chk("b2b access_count", log_q.size(), 10);
    if (log_q.size() == 10) begin
      chk("b2b e1 q3", int'(log_q[4]), int'({1'b1, GLITCH_QUEUE_3, 8'h11}));
      chk("b2b e2 q0", int'(log_q[6]), int'({1'b1, GLITCH_QUEUE_0, 8'hEF}));
      chk("b2b e2 q3", int'(log_q[9]), int'({1'b1, GLITCH_QUEUE_3, 8'hCA}));
    end
    chk("b2b done_err_overlap", cnt_both, 0);
    repeat (3) @(negedge clk_i);

    // ack withheld on the QUEUE_2 write
    log_q.delete();
    n_stb = 0;
    hold_en = 1'b1;
    hold_adr = GLITCH_QUEUE_2;
    send_entry(32'hDEADBEEF);
    watch(40, -1, -1);
    hold_en = 1'b0;
    chk("to stb_wr2_start", int'(stb_hist[9]), 1);
    chk("to stb_last_high", int'(stb_hist[24]), 1);
    chk("to stb_dropped", int'(stb_hist[25]), 0);
    chk("to err_cycle", first_err, 25);
    chk("to err_count", cnt_err, 1);
    chk("to done_count", cnt_done, 0);
    chk("to ready_at_err", int'(rdy_hist[25]), 1);
    chk("to access_count", log_q.size(), 3);
    chk("to strobes", n_stb, 4);
    repeat (3) @(negedge clk_i);

    // status request during WR1 waits for the entry
    log_q.delete();
    sts_val = 1'b1;
    empty_val = 1'b0;
    send_entry(32'h0BADF00D);
    watch(26, -1, 6);
    chk("stsmid done_cycle", first_done, 14);
    chk("stsmid sv_cycle", first_sv, 20);
    chk("stsmid sv_count", cnt_sv, 1);
    chk("stsmid sts_ready", int'(sts_ready_o), 1);
    chk("stsmid sts_empty", int'(sts_empty_o), 0);
    chk("stsmid access_count", log_q.size(), 7);
    if (log_q.size() == 7) begin
      chk("stsmid q3_before_sts", int'(log_q[4][11:8]), int'(GLITCH_QUEUE_3));
      chk("stsmid status_adr", int'(log_q[5][11:8]), int'(GLITCH_STATUS));
      chk("stsmid empty_adr", int'(log_q[6][11:8]), int'(GLITCH_FIFO_EMPTY));
    end
    repeat (3) @(negedge clk_i);

    // standalone status snapshot
    sts_val = 1'b0;
    empty_val = 1'b1;
    watch(12, -1, 0);
    chk("sts stb_rise", int'(stb_hist[2]), 1);
    chk("sts sv_cycle", first_sv, 7);
    chk("sts sv_count", cnt_sv, 1);
    chk("sts sts_ready", int'(sts_ready_o), 0);
    chk("sts sts_empty", int'(sts_empty_o), 1);
    repeat (3) @(negedge clk_i);

    // reset during WR1
    sts_val = 1'b1;
    empty_val = 1'b1;
    watch(12, -1, 0);
    chk("pre-rst sts_empty", int'(sts_empty_o), 1);
    send_entry(32'h55AA33CC);
    watch(7, -1, -1);
    chk("pre-rst stb_in_wr1", int'(stb_o), 1);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    log_q.delete();
    n_stb = 0;
    watch(20, -1, -1);
    chk("post-rst strobes", n_stb, 0);
    chk("post-rst done_count", cnt_done, 0);
    chk("post-rst err_count", cnt_err, 0);
    chk("post-rst access_count", log_q.size(), 0);

    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
